ds1307_target: RTL and testbench
================================

# ds1307_target

- Synthesizable I2C target that emulates the DS1307 real-time clock register set.
- Uses for the same I2C master and control path that configures and reads the clock:
  - in-FPGA loopback when no RTC chip is fitted;
  - bench responder for the time write and the 3-byte read.
- Decodes START, address, write and read phases on oversampled SCL/SDA.
- Serves an 8-register file with auto-incrementing pointer and keeps BCD time from a 1 Hz tick.

## Interface

Parameters:
- `DEV_ADDR`, 7'b1101000, 7-bit target address.
- `NUM_REGS`, 8, register count; pointer wraps at `NUM_REGS-1`.

Ports:
- `clk`  in  1  system clock; must be at least 20x SCL.
- `reset`  in  1  asynchronous, active-low reset.
- `scl_in`  in  1  raw SCL from pad, asynchronous.
- `sda_in`  in  1  raw SDA from pad, asynchronous.
- `sda_oe`  out  1  1 = pull SDA low (open-drain); 0 = release.
- `tick_1hz`  in  1  one-`clk` pulse per second.
- `busy`  out  1  high from START to STOP or ignore.
- `time_sec`, `time_min`, `time_hr`  out  8 each  live registers 0x00/0x01/0x02.

## Operation

Reset values:
- `sda_oe`=0, `busy`=0, pointer=0.
- reg0=0x80 (CH set), all other registers 0x00.

Line conditioning:
- `scl_in` and `sda_in` each pass through a 2-FF synchronizer.
- Edges are detected on synchronized values.
- START: SDA falls while SCL high. STOP: SDA rises while SCL high.
- START or repeated START is recognized in any state and restarts the address phase.

States:
- IDLE: waits for START.
- ADDR: shift 8 bits on SCL rising edges, MSB first.
  - addr == `DEV_ADDR` -> ADDR_ACK.
  - Mismatch -> IGNORE. SDA is never driven.
- ADDR_ACK: drive ACK for one SCL period.
  - R/W=0 -> WR_PTR. R/W=1 -> RD_DATA.
- WR_PTR: receive byte, ACK, pointer <= byte mod `NUM_REGS` -> WR_DATA.
- WR_DATA: receive byte, ACK, reg[ptr] <= byte, ptr++ with wrap; repeat.
- RD_DATA: drive shadow[ptr] MSB first, releasing SDA for 1s.
  - After 8 bits, ptr++ -> RD_ACK.
- RD_ACK: sample master bit on SCL rise. ACK (0) -> RD_DATA. NACK (1) -> IGNORE.
- IGNORE: release SDA and wait for STOP/START.
- STOP from any state -> IDLE, `busy`=0.

Shadow:
- At every START, all registers are copied into a shadow bank.
- Reads serve the shadow bank, so a multi-byte read is coherent across a tick.

Timekeeping (live registers):
- On `tick_1hz` with reg0[7]=0: BCD increment of sec.
- Carry chain:
  - sec 0x59 -> 0x00, carries to min.
  - min 0x59 -> 0x00, carries to hr.
  - hr[5:0] 0x23 -> 0x00.
- hr[7:6] are held. Registers 3..7 are plain storage.
- BCD increment rule: low nibble 9 -> 0 and high nibble +1; otherwise low +1.
- Invalid BCD values are not trapped; they follow the rule above.
- Tick and I2C write to the same register in the same cycle: the write wins and the carry is dropped.

## Timing

- Synchronizer latency: 2 `clk`. Edge detection adds 1 `clk`.
- `sda_oe` updates on the 3rd `clk` after the raw SCL falling edge, i.e. during SCL low only.
  - It is never changed while SCL is high, except release on STOP/START detect.
- ACK is asserted after the SCL fall following bit 8 and released after the next SCL fall.
- Register write takes effect 1 `clk` after the 8th SCL rise of the data byte.
- Tick increment is visible on `time_*` 1 `clk` after `tick_1hz`.
- Asynchronous reset mid-transaction:
  - immediate release of SDA, state IDLE, registers to reset values;
  - the transaction in flight is abandoned and the target waits for a fresh START.

## Structure

- Package `ds1307_pkg`:
  - `DEV_ADDR` default;
  - register index constants (SEC=0, MIN=1, HR=2, CTRL=7);
  - CH bit position;
  - state enumeration.
- Sub-module `i2c_line_sync`: synchronizers plus `scl_rise`, `scl_fall`, `start_det`, `stop_det` outputs.
- Top contains the protocol FSM, register file, shadow bank and BCD counter.

## Test plan

- Time write:
  - Stimulus: START, 0xD0, 0x00, 0x45, 0x30, 0x12, STOP.
  - Expected: all bytes ACKed, then `time_sec`=0x45, `time_min`=0x30, `time_hr`=0x12.
- Read with pointer and wrap:
  - Stimulus: set pointer 0x06, repeated START, 0xD1, read 3 bytes with ACK, ACK, NACK.
  - Expected: data reg6, reg7, reg0, then SDA released.
- Address mismatch:
  - Stimulus: START, 0xA0, 0x00, STOP.
  - Expected: `sda_oe` stays 0 throughout and registers are unchanged.
- Tick rollover:
  - Stimulus: write 0x59/0x59/0x23, then one tick.
  - Expected: 0x00/0x00/0x00.
- Clock halt:
  - Stimulus: write sec=0x80, then 3 ticks.
  - Expected: sec unchanged.
  - Then write 0x10, then 3 ticks: sec=0x13.
- Reset and shadow coherence:
  - Stimulus: assert `reset` low mid-ACK.
  - Expected: `sda_oe`=0 immediately and reg0=0x80.
  - Stimulus: tick during a 3-byte read.
  - Expected: the read returns the values latched at START.

Source files
------------

// File: rtl/ds1307_pkg.sv
// Shared constants for the DS1307-compatible I2C target: address, register map,
// FSM state encodings and the BCD increment helper.
package ds1307_pkg;

    localparam logic [6:0] DEV_ADDR_DEF = 7'b1101000;

    localparam int REG_SEC  = 0;
    localparam int REG_MIN  = 1;
    localparam int REG_HR   = 2;
    localparam int REG_CTRL = 7;

    localparam int CH_BIT = 7;

    localparam logic [7:0] RESET_SEC = 8'h80;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_ADDR     = 3'd1;
    localparam logic [2:0] ST_ADDR_ACK = 3'd2;
    localparam logic [2:0] ST_WR_PTR   = 3'd3;
    localparam logic [2:0] ST_WR_DATA  = 3'd4;
    localparam logic [2:0] ST_RD_DATA  = 3'd5;
    localparam logic [2:0] ST_RD_ACK   = 3'd6;
    localparam logic [2:0] ST_IGNORE   = 3'd7;

    // Invalid digits are not trapped; they simply follow the nibble rule.
    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        logic [7:0] r;
        if (v[3:0] == 4'd9) begin
            r = {v[7:4] + 4'd1, 4'd0};
        end else begin
            r = {v[7:4], v[3:0] + 4'd1};
        end
        return r;
    endfunction

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers on raw SCL/SDA plus edge and START/STOP detection
// on the synchronized values.
module i2c_line_sync (
    input  logic clk,
    input  logic reset,
    input  logic scl_i,
    input  logic sda_i,
    output logic scl_o,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [1:0] scl_ff_q;
    logic [1:0] sda_ff_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Idle bus is high, so flops come out of reset as 1 to avoid false edges.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            scl_ff_q   <= 2'b11;
            sda_ff_q   <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_ff_q   <= {scl_ff_q[0], scl_i};
            sda_ff_q   <= {sda_ff_q[0], sda_i};
            scl_prev_q <= scl_ff_q[1];
            sda_prev_q <= sda_ff_q[1];
        end
    end

    assign scl_o       = scl_ff_q[1];
    assign sda_o       = sda_ff_q[1];
    assign scl_rise_o  = scl_ff_q[1] & ~scl_prev_q;
    assign scl_fall_o  = ~scl_ff_q[1] & scl_prev_q;
    assign start_det_o = scl_ff_q[1] & scl_prev_q & sda_prev_q & ~sda_ff_q[1];
    assign stop_det_o  = scl_ff_q[1] & scl_prev_q & ~sda_prev_q & sda_ff_q[1];

endmodule

// File: rtl/ds1307_target.sv
// I2C target emulating the DS1307 register set: protocol FSM, live register
// file with BCD timekeeping, and a shadow bank captured at every START.
//
// state       | meaning
// ST_IDLE     | waiting for START
// ST_ADDR     | shifting in address + R/W
// ST_ADDR_ACK | driving address ACK for one SCL period
// ST_WR_PTR   | receiving register pointer byte, then ACK
// ST_WR_DATA  | receiving data bytes into reg[ptr], ACK each
// ST_RD_DATA  | driving shadow[ptr] MSB first
// ST_RD_ACK   | sampling master ACK/NACK
// ST_IGNORE   | bus released until STOP/START
module ds1307_target
    import ds1307_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
    parameter int          NUM_REGS = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic       tick_1hz,
    output logic       busy,
    output logic [7:0] time_sec,
    output logic [7:0] time_min,
    output logic [7:0] time_hr
);

    localparam int PW = $clog2(NUM_REGS);

    logic scl_s, sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk         (clk),
        .reset       (reset),
        .scl_i       (scl_in),
        .sda_i       (sda_in),
        .scl_o       (scl_s),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    logic [2:0]    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    tx_q, tx_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          ack_q, ack_d;
    logic          rw_q, rw_d;
    logic          mack_q, mack_d;
    logic          sda_oe_q, sda_oe_d;

    logic [7:0] regs_q   [NUM_REGS];
    logic [7:0] regs_d   [NUM_REGS];
    logic [7:0] shadow_q [NUM_REGS];

    logic          wr_en;
    logic          snap;
    logic [7:0]    rx_byte;
    logic [PW-1:0] ptr_inc;

    assign rx_byte = {shift_q[6:0], sda_s};
    assign ptr_inc = (ptr_q == PW'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        ptr_d     = ptr_q;
        ack_d     = ack_q;
        rw_d      = rw_q;
        mack_d    = mack_q;
        sda_oe_d  = sda_oe_q;
        wr_en     = 1'b0;
        snap      = 1'b0;

        if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            ack_d    = 1'b0;
            mack_d   = 1'b0;
        end else if (start_det) begin
            state_d   = ST_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            ack_d     = 1'b0;
            mack_d    = 1'b0;
            snap      = 1'b1;
        end else begin
            case (state_q)
                ST_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = rx_byte;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = rx_byte[0];
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end
                    end
                end

                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            ack_d     = 1'b0;
                            bit_cnt_d = '0;
                            if (rw_q) begin
                                state_d  = ST_RD_DATA;
                                tx_d     = shadow_q[ptr_q];
                                sda_oe_d = ~shadow_q[ptr_q][7];
                            end else begin
                                state_d  = ST_WR_PTR;
                                sda_oe_d = 1'b0;
                            end
                        end
                    end
                end

                // bit_cnt == 8 marks the ACK slot; the 9th SCL rise is not data.
                ST_WR_PTR, ST_WR_DATA: begin
                    if (bit_cnt_q != 4'd8) begin
                        if (scl_rise) begin
                            shift_d   = rx_byte;
                            bit_cnt_d = bit_cnt_q + 4'd1;
                            if (bit_cnt_q == 4'd7) begin
                                if (state_q == ST_WR_PTR) begin
                                    ptr_d = PW'(rx_byte % NUM_REGS);
                                end else begin
                                    wr_en = 1'b1;
                                    ptr_d = ptr_inc;
                                end
                            end
                        end
                    end else if (scl_fall) begin
                        if (!ack_q) begin
                            sda_oe_d = 1'b1;
                            ack_d    = 1'b1;
                        end else begin
                            sda_oe_d  = 1'b0;
                            ack_d     = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_WR_DATA;
                        end
                    end
                end

                ST_RD_DATA: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (bit_cnt_q == 4'd7) begin
                            ptr_d = ptr_inc;
                        end
                    end else if (scl_fall) begin
                        if (bit_cnt_q == 4'd8) begin
                            sda_oe_d = 1'b0;
                            mack_d   = 1'b0;
                            state_d  = ST_RD_ACK;
                        end else begin
                            sda_oe_d = ~tx_q[6];
                            tx_d     = {tx_q[6:0], 1'b0};
                        end
                    end
                end

                ST_RD_ACK: begin
                    if (scl_rise) begin
                        if (sda_s) begin
                            state_d = ST_IGNORE;
                        end else begin
                            mack_d = 1'b1;
                        end
                    end else if (scl_fall && mack_q) begin
                        mack_d    = 1'b0;
                        bit_cnt_d = '0;
                        state_d   = ST_RD_DATA;
                        tx_d      = shadow_q[ptr_q];
                        sda_oe_d  = ~shadow_q[ptr_q][7];
                    end
                end

                ST_IGNORE: begin
                    sda_oe_d = 1'b0;
                end

                default: begin
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    logic       tick_en;
    logic       sec_wrap, min_wrap;
    logic [7:0] sec_inc, min_inc, hr_inc;

    assign tick_en  = tick_1hz & ~regs_q[REG_SEC][CH_BIT];
    assign sec_wrap = (regs_q[REG_SEC] == 8'h59);
    assign min_wrap = (regs_q[REG_MIN] == 8'h59);
    assign sec_inc  = bcd_inc(regs_q[REG_SEC]);
    assign min_inc  = bcd_inc(regs_q[REG_MIN]);
    assign hr_inc   = bcd_inc({2'b00, regs_q[REG_HR][5:0]});

    // An I2C write to a register overrides that register's tick update.
    always_comb begin
        regs_d = regs_q;
        if (tick_en) begin
            regs_d[REG_SEC] = sec_wrap ? 8'h00 : sec_inc;
            if (sec_wrap) begin
                regs_d[REG_MIN] = min_wrap ? 8'h00 : min_inc;
                if (min_wrap) begin
                    regs_d[REG_HR] = {regs_q[REG_HR][7:6],
                                      (regs_q[REG_HR][5:0] == 6'h23) ? 6'h00 : hr_inc[5:0]};
                end
            end
        end
        if (wr_en) begin
            regs_d[ptr_q] = rx_byte;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= '0;
            ptr_q     <= '0;
            ack_q     <= 1'b0;
            rw_q      <= 1'b0;
            mack_q    <= 1'b0;
            sda_oe_q  <= 1'b0;
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i]   <= (i == REG_SEC) ? RESET_SEC : 8'h00;
                shadow_q[i] <= (i == REG_SEC) ? RESET_SEC : 8'h00;
            end
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            ptr_q     <= ptr_d;
            ack_q     <= ack_d;
            rw_q      <= rw_d;
            mack_q    <= mack_d;
            sda_oe_q  <= sda_oe_d;
            regs_q    <= regs_d;
            if (snap) begin
                shadow_q <= regs_q;
            end
        end
    end

    assign sda_oe   = sda_oe_q;
    assign busy     = (state_q != ST_IDLE);
    assign time_sec = regs_q[REG_SEC];
    assign time_min = regs_q[REG_MIN];
    assign time_hr  = regs_q[REG_HR];

endmodule

// File: tb/tb_ds1307_target.sv
// Directed bench for ds1307_target: bit-banged I2C master on an open-drain bus
// with hand-computed expected register and data values.
module tb_ds1307_target;

    localparam int T = 10;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       tick_1hz = 1'b0;
    logic       sda_oe;
    logic       busy;
    logic [7:0] time_sec, time_min, time_hr;
    wire        sda_line = sda_m & ~sda_oe;

    int n_chk = 0;
    int n_err = 0;
    int oe_cnt = 0;
    int oe_base;

    always #5 clk = ~clk;

    always @(posedge clk) if (sda_oe) oe_cnt <= oe_cnt + 1;

    ds1307_target dut (
        .clk      (clk),
        .reset    (reset),
        .scl_in   (scl_m),
        .sda_in   (sda_line),
        .sda_oe   (sda_oe),
        .tick_1hz (tick_1hz),
        .busy     (busy),
        .time_sec (time_sec),
        .time_min (time_min),
        .time_hr  (time_hr)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start;
        sda_m = 1'b1; wclk(T);
        scl_m = 1'b1; wclk(T);
        sda_m = 1'b0; wclk(T);
        scl_m = 1'b0; wclk(2);
    endtask

    task automatic i2c_stop;
        sda_m = 1'b0; wclk(T);
        scl_m = 1'b1; wclk(T);
        sda_m = 1'b1; wclk(T);
    endtask

    task automatic send_bits(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = b[i]; wclk(T);
            scl_m = 1'b1; wclk(T);
            scl_m = 1'b0; wclk(2);
        end
    endtask

    task automatic ack_clock(output logic ack);
        sda_m = 1'b1; wclk(T);
        scl_m = 1'b1; wclk(T/2);
        ack = ~sda_line; wclk(T/2);
        scl_m = 1'b0; wclk(2);
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b);
        ack_clock(ack);
    endtask

    task automatic read_byte(input logic nack, output logic [7:0] b);
        b = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wclk(T);
            scl_m = 1'b1; wclk(T/2);
            b = {b[6:0], sda_line}; wclk(T/2);
            scl_m = 1'b0; wclk(2);
        end
        sda_m = nack; wclk(T);
        scl_m = 1'b1; wclk(T);
        scl_m = 1'b0; wclk(2);
    endtask

    task automatic wr_regs(input string tag, input logic [7:0] ptr, input int n,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        logic a;
        logic all_ack;
        logic [7:0] d [3];
        d[0] = d0; d[1] = d1; d[2] = d2;
        i2c_start;
        write_byte(8'hD0, a); all_ack = a;
        write_byte(ptr, a);   all_ack &= a;
        for (int i = 0; i < n; i++) begin
            write_byte(d[i], a); all_ack &= a;
        end
        i2c_stop;
        check_eq(tag, {31'd0, all_ack}, 32'd1);
    endtask

    task automatic pulse_tick;
        tick_1hz = 1'b1; wclk(1);
        tick_1hz = 1'b0;
    endtask

    initial begin
        logic       a;
        logic [7:0] rd;

        // reset state
        wclk(3);
        check_eq("rst_oe", {31'd0, sda_oe}, 0);
        check_eq("rst_busy", {31'd0, busy}, 0);
        check_eq("rst_sec", {24'd0, time_sec}, 32'h80);
        check_eq("rst_min", {24'd0, time_min}, 32'h00);
        check_eq("rst_hr", {24'd0, time_hr}, 32'h00);
        reset = 1'b1; wclk(5);

        // time write
        i2c_start;
        check_eq("tw_busy", {31'd0, busy}, 1);
        write_byte(8'hD0, a); check_eq("tw_ack_addr", {31'd0, a}, 1);
        write_byte(8'h00, a); check_eq("tw_ack_ptr", {31'd0, a}, 1);
        write_byte(8'h45, a); check_eq("tw_ack_d0", {31'd0, a}, 1);
        write_byte(8'h30, a); check_eq("tw_ack_d1", {31'd0, a}, 1);
        write_byte(8'h12, a); check_eq("tw_ack_d2", {31'd0, a}, 1);
        i2c_stop;
        check_eq("tw_sec", {24'd0, time_sec}, 32'h45);
        check_eq("tw_min", {24'd0, time_min}, 32'h30);
        check_eq("tw_hr", {24'd0, time_hr}, 32'h12);
        check_eq("tw_idle", {31'd0, busy}, 0);

        // read with pointer wrap 6 -> 7 -> 0
        wr_regs("r67_ack", 8'h06, 2, 8'hA6, 8'h7C, 8'h00);
        i2c_start;
        write_byte(8'hD0, a); check_eq("rd_ack_addr", {31'd0, a}, 1);
        write_byte(8'h06, a); check_eq("rd_ack_ptr", {31'd0, a}, 1);
        i2c_start;
        write_byte(8'hD1, a); check_eq("rd_ack_raddr", {31'd0, a}, 1);
        read_byte(1'b0, rd); check_eq("rd_reg6", {24'd0, rd}, 32'hA6);
        read_byte(1'b0, rd); check_eq("rd_reg7", {24'd0, rd}, 32'h7C);
        read_byte(1'b1, rd); check_eq("rd_reg0", {24'd0, rd}, 32'h45);
        wclk(4);
        check_eq("rd_release", {31'd0, sda_oe}, 0);
        check_eq("rd_ignore_busy", {31'd0, busy}, 1);
        i2c_stop;
        check_eq("rd_idle", {31'd0, busy}, 0);

        // address mismatch
        oe_base = oe_cnt;
        i2c_start;
        write_byte(8'hA0, a); check_eq("mm_noack_addr", {31'd0, a}, 0);
        write_byte(8'h00, a); check_eq("mm_noack_d", {31'd0, a}, 0);
        i2c_stop;
        check_eq("mm_oe_never", oe_cnt - oe_base, 0);
        check_eq("mm_sec", {24'd0, time_sec}, 32'h45);
        check_eq("mm_min", {24'd0, time_min}, 32'h30);
        check_eq("mm_hr", {24'd0, time_hr}, 32'h12);

        // tick rollover
        wr_regs("ro_ack", 8'h00, 3, 8'h59, 8'h59, 8'h23);
        pulse_tick;
        check_eq("ro_sec", {24'd0, time_sec}, 32'h00);
        check_eq("ro_min", {24'd0, time_min}, 32'h00);
        check_eq("ro_hr", {24'd0, time_hr}, 32'h00);
        wr_regs("ro12_ack", 8'h00, 3, 8'h59, 8'h59, 8'h63);
        pulse_tick;
        check_eq("ro12_hr", {24'd0, time_hr}, 32'h40);
        wr_regs("nc_ack", 8'h00, 3, 8'h09, 8'h59, 8'h09);
        pulse_tick;
        check_eq("nc_sec", {24'd0, time_sec}, 32'h10);
        check_eq("nc_min", {24'd0, time_min}, 32'h59);

        // clock halt
        wr_regs("ch_ack", 8'h00, 1, 8'h80, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin pulse_tick; wclk(3); end
        check_eq("ch_halt_sec", {24'd0, time_sec}, 32'h80);
        wr_regs("ch_run_ack", 8'h00, 1, 8'h10, 8'h00, 8'h00);
        for (int i = 0; i < 3; i++) begin pulse_tick; wclk(3); end
        check_eq("ch_run_sec", {24'd0, time_sec}, 32'h13);

        // shadow coherence across a tick
        wr_regs("sh_ack", 8'h00, 3, 8'h59, 8'h59, 8'h11);
        i2c_start;
        write_byte(8'hD0, a);
        write_byte(8'h00, a);
        i2c_start;
        write_byte(8'hD1, a); check_eq("sh_ack_raddr", {31'd0, a}, 1);
        read_byte(1'b0, rd); check_eq("sh_sec", {24'd0, rd}, 32'h59);
        pulse_tick;
        read_byte(1'b0, rd); check_eq("sh_min", {24'd0, rd}, 32'h59);
        read_byte(1'b1, rd); check_eq("sh_hr", {24'd0, rd}, 32'h11);
        i2c_stop;
        check_eq("sh_live_sec", {24'd0, time_sec}, 32'h00);
        check_eq("sh_live_min", {24'd0, time_min}, 32'h00);
        check_eq("sh_live_hr", {24'd0, time_hr}, 32'h12);

        // asynchronous reset during address ACK
        i2c_start;
        send_bits(8'hD0);
        wclk(2);
        check_eq("ra_ack_on", {31'd0, sda_oe}, 1);
        reset = 1'b0;
        #1;
        check_eq("ra_oe_rel", {31'd0, sda_oe}, 0);
        check_eq("ra_busy", {31'd0, busy}, 0);
        check_eq("ra_sec", {24'd0, time_sec}, 32'h80);
        check_eq("ra_hr", {24'd0, time_hr}, 32'h00);
        wclk(2);
        reset = 1'b1;
        wclk(3);
        oe_base = oe_cnt;
        ack_clock(a);
        write_byte(8'hD0, a); check_eq("ra_nostart_noack", {31'd0, a}, 0);
        check_eq("ra_nostart_oe", oe_cnt - oe_base, 0);
        i2c_stop;
        wr_regs("ra_fresh_ack", 8'h00, 1, 8'h05, 8'h00, 8'h00);
        check_eq("ra_fresh_sec", {24'd0, time_sec}, 32'h05);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
